pipe_pair_gen: RTL and testbench
================================

PIPE_PAIR_GEN -- requirements
Module: pipe_pair_gen

Interface
REQ-001 Parameter PIPE_W, 41, pipe texture width in pixels.
REQ-002 Parameter PIPE_H, 253, pipe texture height in rows.
REQ-003 Parameter GAP, 70, initial vertical gap between high and low pipe.
REQ-004 Parameter GAP_MIN, 50, smallest gap allowed (shrink feature only).
REQ-005 Parameter GAP_T_MIN, 60, smallest gap top row; GAP_T_MIN+255+GAP SHALL be <= MAX_Y.
REQ-006 Parameter MAX_Y, 426, ground row; the low pipe ends at MAX_Y-1.
REQ-007 Parameter SCREEN_W, 640, x loaded on wrap.
REQ-008 Parameter START_X, 400, x loaded in IDLE.
REQ-009 Parameter SPEED, 1, pixels moved per game_tick (1..8).
REQ-010 Parameter SEED, 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-011 Port system_clk  in  1  sole clock.
REQ-012 Port reset  in  1  synchronous, active-high reset.
REQ-013 Port game_tick  in  1  one-cycle movement strobe, synchronous to system_clk.
REQ-014 Port start  in  1  level; launches or relaunches the pipe.
REQ-015 Port freeze  in  1  level; collision stop.
REQ-016 Port bird_x  in  10  bird column used for scoring.
REQ-017 Port pixel_x, pixel_y  in  10 each  current VGA pixel.
REQ-018 Port pipe_l, pipe_r  out  10 each  pipe column bounds (pipe_r = pipe_l+PIPE_W-1).
REQ-019 Port gap_t, gap_b  out  10 each  first open row, first low-pipe row (gap_b = gap_t+gap).
REQ-020 Port rom_addr  out  14  texture ROM address for the current pixel.
REQ-021 Port in_pipe  out  1  current pixel lies on a pipe; rom_sel  out  1  0=high, 1=low texture.
REQ-022 Port passed  out  1  one-cycle score pulse.

Function
REQ-023 The FSM SHALL have states IDLE, RUN, FROZEN: IDLE->RUN on start; RUN->FROZEN on freeze (freeze wins over start); FROZEN->IDLE on start.
REQ-024 In IDLE, pipe_l SHALL equal START_X, gap_t GAP_T_MIN, gap GAP.
REQ-025 In RUN, on a cycle with game_tick=1 and registered state RUN, pipe_l SHALL decrease by SPEED; ticks in IDLE/FROZEN SHALL be ignored.
REQ-026 Wrap: if pipe_l < SPEED on a RUN tick, pipe_l SHALL load SCREEN_W and gap_t SHALL load GAP_T_MIN + lfsr[7:0] in the same cycle; no passed pulse that cycle.
REQ-027 The 16-bit LFSR (taps 16,14,13,11, Fibonacci, shift left) SHALL advance every cycle not in reset, in all states.
REQ-028 passed SHALL pulse for one cycle when a non-wrap RUN tick moves pipe_r from >= bird_x to < bird_x.
REQ-029 In FROZEN, pipe_l, gap_t and gap SHALL hold.
REQ-030 Pixel path SHALL have exactly one cycle latency: in_pipe, rom_sel, rom_addr registered from pixel_x/pixel_y of the previous cycle.
REQ-031 High hit: pipe_l<=pixel_x<=pipe_r and pixel_y<gap_t; rom_sel=0; row = PIPE_H-gap_t+pixel_y.
REQ-032 Low hit: same columns and gap_b<=pixel_y<MAX_Y; rom_sel=1; row = pixel_y-gap_b.
REQ-033 rom_addr SHALL be (pixel_x-pipe_l)+PIPE_W*row truncated to 14 bits on hit, 0 otherwise; in_pipe=0 when neither hits.
REQ-034 High-hit rows with gap_t > PIPE_H + pixel_y SHALL produce in_pipe=0 (texture exhausted).

Reset
REQ-035 On reset: state IDLE, pipe_l=START_X, gap_t=GAP_T_MIN, gap=GAP, lfsr=SEED, in_pipe=0, rom_sel=0, rom_addr=0, passed=0; reset SHALL override all other inputs, including mid-move.

Configuration
REQ-036 Macro PIPE_GAP_SHRINK_EN defined: each wrap SHALL reduce gap by 2, saturating at GAP_MIN; IDLE/reset reload GAP.
REQ-037 Macro PIPE_GAP_SHRINK_EN undefined: gap SHALL be constant GAP; GAP_MIN unused.

Verification
REQ-038 Reset, start, 10 ticks at SPEED=1 -> pipe_l=390, pipe_r=430, gap_b=130.
REQ-039 pipe_l=0, tick in RUN -> pipe_l=640, gap_t=60+lfsr[7:0], passed=0.
REQ-040 bird_x=100, pipe_r 100->99 on tick -> passed high exactly one cycle.
REQ-041 freeze and start together in RUN -> FROZEN; ticks leave pipe_l unchanged; start -> IDLE, pipe_l=400.
REQ-042 pipe_l=400, gap_t=60, pixel (405,140) -> next cycle in_pipe=1, rom_sel=1, rom_addr=415.
REQ-043 PIPE_GAP_SHRINK_EN defined, 12 wraps -> gap=50, gap_b=gap_t+50.

Source files
------------

// File: rtl/pipe_pair_gen_if.sv
// pipe_pair_gen_if -- game-side and pixel-side signals of one pipe pair.
// The slave modport is the generator's view; the master modport is the
// view of whatever drives the game inputs and consumes the pipe outputs.
interface pipe_pair_gen_if;
  // game control
  logic        game_tick;
  logic        start;
  logic        freeze;
  logic [9:0]  bird_x;
  // current VGA pixel
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  // pipe geometry
  logic [9:0]  pipe_l;
  logic [9:0]  pipe_r;
  logic [9:0]  gap_t;
  logic [9:0]  gap_b;
  // pixel result, one cycle behind pixel_x/pixel_y
  logic [13:0] rom_addr;
  logic        in_pipe;
  logic        rom_sel;
  // score strobe
  logic        passed;

  modport slave (
    input  game_tick, start, freeze, bird_x, pixel_x, pixel_y,
    output pipe_l, pipe_r, gap_t, gap_b, rom_addr, in_pipe, rom_sel, passed
  );

  modport master (
    output game_tick, start, freeze, bird_x, pixel_x, pixel_y,
    input  pipe_l, pipe_r, gap_t, gap_b, rom_addr, in_pipe, rom_sel, passed
  );
endinterface

// File: rtl/pipe_pair_gen.sv
// pipe_pair_gen -- one scrolling high/low pipe pair for a flappy-bird game.
// The pipe moves left by SPEED on every game_tick while running, wraps to
// SCREEN_W with a new LFSR-chosen gap position, pulses passed when its right
// edge crosses the bird, and maps the current VGA pixel to a texture ROM
// address with one cycle of latency.
// Optional feature: define PIPE_GAP_SHRINK_EN to shrink the gap by 2 on every
// wrap (saturating at GAP_MIN); otherwise the gap stays at GAP.
module pipe_pair_gen #(
  parameter int          PIPE_W    = 41,
  parameter int          PIPE_H    = 253,
  parameter int          GAP       = 70,
  parameter int          GAP_MIN   = 50,
  parameter int          GAP_T_MIN = 60,
  parameter int          MAX_Y     = 426,
  parameter int          SCREEN_W  = 640,
  parameter int          START_X   = 400,
  parameter int          SPEED     = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic           system_clk,
  input  logic           reset,
  pipe_pair_gen_if.slave bus
);

  localparam logic [9:0]  PIPE_W_M1   = 10'(PIPE_W - 1);
  localparam logic [9:0]  START_X_V   = 10'(START_X);
  localparam logic [9:0]  SCREEN_W_V  = 10'(SCREEN_W);
  localparam logic [9:0]  GAP_T_MIN_V = 10'(GAP_T_MIN);
  localparam logic [9:0]  GAP_V       = 10'(GAP);
  localparam logic [9:0]  MAX_Y_V     = 10'(MAX_Y);
  localparam logic [9:0]  SPEED_V     = 10'(SPEED);
  localparam logic [10:0] PIPE_H_V    = 11'(PIPE_H);
  localparam logic [13:0] PIPE_W_V    = 14'(PIPE_W);
`ifdef PIPE_GAP_SHRINK_EN
  localparam logic [9:0]  GAP_MIN_V   = 10'(GAP_MIN);
`endif

  // Reject parameter sets that would put the low pipe below the ground,
  // lock the LFSR at zero, or shrink the gap upwards.
  if (SEED == 16'h0000 || SPEED < 1 || SPEED > 8 || GAP_MIN > GAP ||
      GAP_T_MIN + 255 + GAP > MAX_Y) begin : g_bad_params
    $error("pipe_pair_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FROZEN
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  pipe_l_q, pipe_l_d;
  logic [9:0]  gap_t_q, gap_t_d;
  logic [9:0]  gap_q, gap_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        passed_q, passed_d;
  logic        in_pipe_q, in_pipe_d;
  logic        rom_sel_q, rom_sel_d;
  logic [13:0] rom_addr_q, rom_addr_d;

  logic [9:0]  pipe_r;
  logic [9:0]  gap_b;
  logic [9:0]  pipe_r_next;
  logic        lfsr_fb;

  // pipe_r and gap_b are pure functions of the registered geometry
  assign pipe_r      = pipe_l_q + PIPE_W_M1;
  assign gap_b       = gap_t_q + gap_q;
  assign pipe_r_next = pipe_l_q - SPEED_V + PIPE_W_M1;
  assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Game state: FSM transitions, pipe movement, wrap, scoring, LFSR.
  always_comb begin
    // NOTE: every _d gets its hold/default value first so no path can infer a latch.
    state_d  = state_q;
    pipe_l_d = pipe_l_q;
    gap_t_d  = gap_t_q;
    gap_d    = gap_q;
    passed_d = 1'b0;
    lfsr_d   = {lfsr_q[14:0], lfsr_fb};

    case (state_q)
      ST_IDLE: begin
        pipe_l_d = START_X_V;
        gap_t_d  = GAP_T_MIN_V;
        gap_d    = GAP_V;
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.game_tick) begin
          if (pipe_l_q < SPEED_V) begin
            // wrap: the pipe re-enters at the right edge with a fresh gap
            pipe_l_d = SCREEN_W_V;
            gap_t_d  = GAP_T_MIN_V + {2'b00, lfsr_q[7:0]};
`ifdef PIPE_GAP_SHRINK_EN
            gap_d    = (gap_q >= GAP_MIN_V + 10'd2) ? gap_q - 10'd2 : GAP_MIN_V;
`endif
          end else begin
            pipe_l_d = pipe_l_q - SPEED_V;
            passed_d = (pipe_r >= bus.bird_x) && (pipe_r_next < bus.bird_x);
          end
        end
        // freeze has priority over start while running
        if (bus.freeze) state_d = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (bus.start) begin
          state_d  = ST_IDLE;
          pipe_l_d = START_X_V;
          gap_t_d  = GAP_T_MIN_V;
          gap_d    = GAP_V;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic        col_hit, hi_hit, lo_hit;
  logic [9:0]  col_off;
  logic [10:0] hi_row, lo_row, row;

  // Pixel classification against the current pipe geometry.
  always_comb begin
    col_hit = (bus.pixel_x >= pipe_l_q) && (bus.pixel_x <= pipe_r);
    // the high texture is PIPE_H rows tall; rows above it are sky
    hi_hit  = col_hit && (bus.pixel_y < gap_t_q) &&
              ({1'b0, gap_t_q} <= PIPE_H_V + {1'b0, bus.pixel_y});
    lo_hit  = col_hit && (bus.pixel_y >= gap_b) && (bus.pixel_y < MAX_Y_V);
    col_off = bus.pixel_x - pipe_l_q;
    hi_row  = PIPE_H_V + {1'b0, bus.pixel_y} - {1'b0, gap_t_q};
    lo_row  = {1'b0, bus.pixel_y - gap_b};
    row     = lo_hit ? lo_row : hi_row;

    in_pipe_d  = hi_hit || lo_hit;
    rom_sel_d  = lo_hit;
    rom_addr_d = (hi_hit || lo_hit) ? 14'(col_off) + PIPE_W_V * 14'(row) : 14'd0;
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge system_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= ST_IDLE;
      pipe_l_q   <= START_X_V;
      gap_t_q    <= GAP_T_MIN_V;
      gap_q      <= GAP_V;
      lfsr_q     <= SEED;
      passed_q   <= 1'b0;
      in_pipe_q  <= 1'b0;
      rom_sel_q  <= 1'b0;
      rom_addr_q <= 14'd0;
    end else begin
      state_q    <= state_d;
      pipe_l_q   <= pipe_l_d;
      gap_t_q    <= gap_t_d;
      gap_q      <= gap_d;
      lfsr_q     <= lfsr_d;
      passed_q   <= passed_d;
      in_pipe_q  <= in_pipe_d;
      rom_sel_q  <= rom_sel_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign bus.pipe_l   = pipe_l_q;
  assign bus.pipe_r   = pipe_r;
  assign bus.gap_t    = gap_t_q;
  assign bus.gap_b    = gap_b;
  assign bus.passed   = passed_q;
  assign bus.in_pipe  = in_pipe_q;
  assign bus.rom_sel  = rom_sel_q;
  assign bus.rom_addr = rom_addr_q;

endmodule

// File: tb/tb_pipe_pair_gen.sv
// tb_pipe_pair_gen -- scoreboard bench for pipe_pair_gen.
// Stimulus tasks update a small behavioural model and queue the expected
// outputs with the cycle they become visible; a monitor on the falling edge
// compares every due entry against the DUT.
module tb_pipe_pair_gen;

  localparam int          PIPE_W    = 41;
  localparam int          GAP       = 70;
  localparam int          GAP_MIN   = 50;
  localparam int          GAP_T_MIN = 60;
  localparam int          SCREEN_W  = 640;
  localparam int          START_X   = 400;
  localparam int          SPEED     = 1;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic system_clk = 1'b0;
  logic reset;

  pipe_pair_gen_if bus ();

  pipe_pair_gen dut (
    .system_clk (system_clk),
    .reset      (reset),
    .bus        (bus.slave)
  );

  always #5 system_clk = ~system_clk;

  typedef enum {S_PIPE_L, S_PIPE_R, S_GAP_T, S_GAP_B,
                S_IN_PIPE, S_ROM_SEL, S_ROM_ADDR, S_PASSED} sig_e;
  typedef enum {M_IDLE, M_RUN, M_FROZEN} mstate_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  // reference model
  mstate_e     st_m;
  int          pl_m, gt_m, gap_m;
  logic [15:0] lfsr_m;

  // Cycle counter and reference LFSR, both stepped on the active edge.
  always @(posedge system_clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= reset ? SEED
                    : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  function automatic logic [31:0] sig_val(input sig_e s);
    case (s)
      S_PIPE_L:   return {22'd0, bus.pipe_l};
      S_PIPE_R:   return {22'd0, bus.pipe_r};
      S_GAP_T:    return {22'd0, bus.gap_t};
      S_GAP_B:    return {22'd0, bus.gap_b};
      S_IN_PIPE:  return {31'd0, bus.in_pipe};
      S_ROM_SEL:  return {31'd0, bus.rom_sel};
      S_ROM_ADDR: return {18'd0, bus.rom_addr};
      default:    return {31'd0, bus.passed};
    endcase
  endfunction

  // Monitor: compare every expectation that has come due, away from the edge.
  always @(negedge system_clk) begin
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act   = sig_val(sb[i].sig);
        total = total + 1;
        if (sb[i].due < cyc || act !== sb[i].exp) begin
          bad = bad + 1;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                   sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic expect_sig(input string nm, input sig_e s, input int v, input int d);
    exp_t e;
    e.name = nm;
    e.sig  = s;
    e.exp  = 32'(v);
    e.due  = cyc + d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  // One clock of game stimulus; the model decides what the next edge produces.
  task automatic cycle(input bit tk, input bit s, input bit f, input bit chk);
    bit pass_e;
    int pr_old, pr_new, bird;
    pass_e        = 1'b0;
    bird          = int'(bus.bird_x);
    bus.game_tick = tk;
    bus.start     = s;
    bus.freeze    = f;
    case (st_m)
      M_IDLE: if (s) st_m = M_RUN;
      M_RUN: begin
        if (tk) begin
          if (pl_m < SPEED) begin
            pl_m = SCREEN_W;
            gt_m = GAP_T_MIN + int'(lfsr_m[7:0]);
`ifdef PIPE_GAP_SHRINK_EN
            gap_m = (gap_m - 2 < GAP_MIN) ? GAP_MIN : gap_m - 2;
`endif
          end else begin
            pr_old = pl_m + PIPE_W - 1;
            pl_m   = pl_m - SPEED;
            pr_new = pl_m + PIPE_W - 1;
            pass_e = (pr_old >= bird) && (pr_new < bird);
          end
        end
        if (f) st_m = M_FROZEN;
      end
      default: if (s) begin
        st_m  = M_IDLE;
        pl_m  = START_X;
        gt_m  = GAP_T_MIN;
        gap_m = GAP;
      end
    endcase
    if (chk) begin
      expect_sig("pipe_l", S_PIPE_L, pl_m, 1);
      expect_sig("pipe_r", S_PIPE_R, pl_m + PIPE_W - 1, 1);
      expect_sig("gap_t",  S_GAP_T,  gt_m, 1);
      expect_sig("gap_b",  S_GAP_B,  gt_m + gap_m, 1);
      expect_sig("passed", S_PASSED, int'(pass_e), 1);
    end
    step();
  endtask

  // One clock with a pixel applied; geometry is left untouched.
  task automatic pix(input int x, input int y, input bit ein, input bit esel, input int eaddr);
    bus.pixel_x = 10'(x);
    bus.pixel_y = 10'(y);
    expect_sig("in_pipe",  S_IN_PIPE,  int'(ein),  1);
    expect_sig("rom_sel",  S_ROM_SEL,  int'(esel), 1);
    expect_sig("rom_addr", S_ROM_ADDR, eaddr,      1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Tick until the pipe sits at column 0, then one more tick to wrap.
  task automatic run_to_wrap();
    for (int k = 0; k < 1000 && pl_m != 0; k++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    int g, gb;
    reset         = 1'b1;
    bus.game_tick = 1'b0;
    bus.start     = 1'b0;
    bus.freeze    = 1'b0;
    bus.bird_x    = 10'd100;
    bus.pixel_x   = 10'd0;
    bus.pixel_y   = 10'd0;
    st_m          = M_IDLE;
    pl_m          = START_X;
    gt_m          = GAP_T_MIN;
    gap_m         = GAP;
    step();
    step();

    // reset state
    expect_sig("rst_pipe_l",   S_PIPE_L,   400, 0);
    expect_sig("rst_pipe_r",   S_PIPE_R,   440, 0);
    expect_sig("rst_gap_t",    S_GAP_T,    60,  0);
    expect_sig("rst_gap_b",    S_GAP_B,    130, 0);
    expect_sig("rst_in_pipe",  S_IN_PIPE,  0,   0);
    expect_sig("rst_rom_sel",  S_ROM_SEL,  0,   0);
    expect_sig("rst_rom_addr", S_ROM_ADDR, 0,   0);
    expect_sig("rst_passed",   S_PASSED,   0,   0);
    reset = 1'b0;

    // pixel path against the IDLE pipe (pipe_l=400, gap_t=60, gap_b=130)
    pix(405, 140, 1'b1, 1'b1, 415);
    pix(410, 30,  1'b1, 1'b0, 9153);
    pix(399, 30,  1'b0, 1'b0, 0);
    pix(440, 425, 1'b1, 1'b1, 12135);
    pix(420, 426, 1'b0, 1'b0, 0);
    pix(441, 200, 1'b0, 1'b0, 0);
    pix(420, 100, 1'b0, 1'b0, 0);
    pix(420, 59,  1'b1, 1'b0, 10352);
    pix(420, 60,  1'b0, 1'b0, 0);

    // tick in IDLE is ignored, then start and ten ticks
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // run to column 0 (scores once on the way), then wait for a tall gap_t
    for (int k = 0; k < 1000 && pl_m != 0; k++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (lfsr_m[7:0] <= 8'd193 && n < 2000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    total = total + 1;
    if (n >= 2000) begin
      bad = bad + 1;
      $display("FAIL lfsr_wait: got no lfsr[7:0] above 193 within %0d cycles expected one", n);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // texture-exhausted rows and gap edges on the freshly wrapped pipe
    g  = gt_m;
    gb = gt_m + gap_m;
    pix(SCREEN_W + 5, g - 254, 1'b0, 1'b0, 0);
    pix(SCREEN_W + 5, g - 253, 1'b1, 1'b0, 5);
    pix(SCREEN_W + 5, gb - 1,  1'b0, 1'b0, 0);
    pix(SCREEN_W + 5, gb,      1'b1, 1'b1, 5);
    pix(SCREEN_W + PIPE_W - 1, gb, 1'b1, 1'b1, PIPE_W - 1);
    pix(SCREEN_W + PIPE_W,     gb, 1'b0, 1'b0, 0);
    bus.pixel_x = 10'd0;
    bus.pixel_y = 10'd0;

    // eleven more wraps (twelve in total)
    for (int w = 0; w < 11; w++) run_to_wrap();

    // freeze wins over start, ticks are ignored, start returns to IDLE
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a move overrides tick and start
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    bus.pixel_x   = 10'd385;
    bus.pixel_y   = 10'd140;
    bus.game_tick = 1'b1;
    bus.start     = 1'b1;
    reset         = 1'b1;
    expect_sig("mid_rst_pipe_l",  S_PIPE_L,   400, 1);
    expect_sig("mid_rst_gap_t",   S_GAP_T,    60,  1);
    expect_sig("mid_rst_gap_b",   S_GAP_B,    130, 1);
    expect_sig("mid_rst_passed",  S_PASSED,   0,   1);
    expect_sig("mid_rst_in_pipe", S_IN_PIPE,  0,   1);
    expect_sig("mid_rst_addr",    S_ROM_ADDR, 0,   1);
    st_m  = M_IDLE;
    pl_m  = START_X;
    gt_m  = GAP_T_MIN;
    gap_m = GAP;
    step();
    reset = 1'b0;
    pix(385, 140, 1'b0, 1'b0, 0);
    pix(405, 140, 1'b1, 1'b1, 415);

    // after reset the LFSR restarts from SEED: the next wrap gap_t shows it
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    run_to_wrap();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // drain the scoreboard
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
